// File: rtl/snake_engine.sv
// snake_engine: grid snake game core (IDLE/RUN/OVER) with a combinational cell renderer.
module snake_engine #(
  parameter int          GRID_W      = 64,
  parameter int          GRID_H      = 48,
  parameter int          CELL_SIZE   = 10,
  parameter int          MAX_LEN     = 16,
  parameter int          INIT_LEN    = 3,
  parameter int          WRAP_MODE   = 0,
  parameter logic [11:0] SNAKE_COLOR = 12'h0F0,
  parameter logic [11:0] HEAD_COLOR  = 12'h080,
  parameter logic [11:0] FOOD_COLOR  = 12'hF00,
  parameter logic [11:0] BACKGROUND  = 12'hFFF,
  parameter logic [11:0] DEAD_COLOR  = 12'hF80,
  localparam int         XW          = $clog2(GRID_W),
  localparam int         YW          = $clog2(GRID_H),
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          start,
  input  logic          game_tick,
  input  logic [1:0]    snake_direction,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [11:0]   rgb,
  output logic [7:0]    score,
  output logic [LW-1:0] snake_length,
  output logic          food_eaten,
  output logic          game_over
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
  localparam logic [1:0] D_RIGHT = 2'd0, D_UP = 2'd1, D_LEFT = 2'd2, D_DOWN = 2'd3;
  localparam logic [YW-1:0] HY0 = YW'(GRID_H / 2);

  state_t        r_state, w_next;
  logic [XW-1:0] r_sx [MAX_LEN];
  logic [YW-1:0] r_sy [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [7:0]    r_score;
  logic          r_eaten, r_over;
  logic [1:0]    r_cur, r_pend;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_wall, w_self, w_grow, w_hit;
  logic          w_food_px, w_head_px, w_body_px, w_in_area;

  // pixel-in-cell test against cell edges, so no divider is needed
  function automatic logic in_cell(input logic [9:0] p, input logic [9:0] c);
    logic [15:0] lo;
    lo = 16'(c) * 16'(CELL_SIZE);
    return (16'(p) >= lo) && (16'(p) < lo + 16'(CELL_SIZE));
  endfunction

  // next head position from the pending direction, with wall detection or wrap
  always_comb begin
    w_nx   = r_sx[0];
    w_ny   = r_sy[0];
    w_wall = 1'b0;
    case (r_pend)
      D_RIGHT: if (r_sx[0] == XW'(GRID_W - 1)) begin w_wall = (WRAP_MODE == 0); w_nx = '0; end
               else w_nx = r_sx[0] + XW'(1);
      D_UP:    if (r_sy[0] == '0) begin w_wall = (WRAP_MODE == 0); w_ny = YW'(GRID_H - 1); end
               else w_ny = r_sy[0] - YW'(1);
      D_LEFT:  if (r_sx[0] == '0) begin w_wall = (WRAP_MODE == 0); w_nx = XW'(GRID_W - 1); end
               else w_nx = r_sx[0] - XW'(1);
      default: if (r_sy[0] == YW'(GRID_H - 1)) begin w_wall = (WRAP_MODE == 0); w_ny = '0; end
               else w_ny = r_sy[0] + YW'(1);
    endcase
  end

  // self-collision: the tail cell is free unless this move grows the snake
  always_comb begin
    w_grow = (w_nx == food_x) && (w_ny == food_y);
    w_self = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (i < int'(r_len) && (w_grow || i != int'(r_len) - 1) &&
          r_sx[i] == w_nx && r_sy[i] == w_ny)
        w_self = 1'b1;
    w_hit = w_wall | w_self;
  end

  // state register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic; start only matters outside RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (game_tick && w_hit) w_next = S_OVER;
      S_OVER:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // snake body, direction, length, score and status flags
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_sx[i] <= XW'(GRID_W / 2 - i);
        r_sy[i] <= HY0;
      end
      r_len   <= LW'(INIT_LEN);
      r_score <= '0;
      r_eaten <= 1'b0;
      r_over  <= 1'b0;
      r_cur   <= D_RIGHT;
      r_pend  <= D_RIGHT;
    end else begin
      r_eaten <= 1'b0;
      if (r_state != S_RUN && start) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          r_sx[i] <= XW'(GRID_W / 2 - i);
          r_sy[i] <= HY0;
        end
        r_len   <= LW'(INIT_LEN);
        r_score <= '0;
        r_over  <= 1'b0;
        r_cur   <= D_RIGHT;
        r_pend  <= D_RIGHT;
      end else if (r_state == S_RUN) begin
        // a direct reversal of the current heading is dropped
        if (snake_direction != (r_cur ^ 2'b10)) r_pend <= snake_direction;
        if (game_tick) begin
          r_cur <= r_pend;
          if (w_hit) begin
            r_over <= 1'b1;
          end else begin
            // shift the whole store; entries past the length are never rendered
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              r_sx[i] <= r_sx[i-1];
              r_sy[i] <= r_sy[i-1];
            end
            r_sx[0] <= w_nx;
            r_sy[0] <= w_ny;
            if (w_grow) begin
              if (r_len != LW'(MAX_LEN)) r_len <= r_len + LW'(1);
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              r_eaten <= 1'b1;
            end
          end
        end
      end
    end
  end

  // renderer: food over head over body over background; dead snake recoloured
  always_comb begin
    w_in_area = (16'(x) < 16'(GRID_W * CELL_SIZE)) && (16'(y) < 16'(GRID_H * CELL_SIZE));
    w_food_px = in_cell(x, 10'(food_x)) && in_cell(y, 10'(food_y));
    w_head_px = in_cell(x, 10'(r_sx[0])) && in_cell(y, 10'(r_sy[0]));
    w_body_px = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (i < int'(r_len) && in_cell(x, 10'(r_sx[i])) && in_cell(y, 10'(r_sy[i])))
        w_body_px = 1'b1;
    rgb = 12'h000;
    if (video_on && w_in_area) begin
      if (w_food_px)      rgb = FOOD_COLOR;
      else if (w_head_px) rgb = (r_state == S_OVER) ? DEAD_COLOR : HEAD_COLOR;
      else if (w_body_px) rgb = (r_state == S_OVER) ? DEAD_COLOR : SNAKE_COLOR;
      else                rgb = BACKGROUND;
    end
  end

  assign score        = r_score;
  assign snake_length = r_len;
  assign food_eaten   = r_eaten;
  assign game_over    = r_over;
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed + random stimulus against a queue-based game model.
module tb_snake_engine;
  localparam int GW = 64, GH = 48, CS = 10, ML = 16, IL = 3;
  localparam int C_SNAKE = 'h0F0, C_HEAD = 'h080, C_FOOD = 'hF00, C_BG = 'hFFF, C_DEAD = 'hF80;
  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

  logic clk_100MHz = 1'b0;
  always #50 clk_100MHz = ~clk_100MHz;

  logic       reset, start, game_tick, video_on;
  logic [1:0] snake_direction;
  logic [5:0] food_x, food_y;
  logic [9:0] px, py;
  logic [11:0] rgb, rgb_w;
  logic [7:0] score, score_w;
  logic [4:0] snake_length, len_w;
  logic       food_eaten, eaten_w, game_over, over_w;
  logic       w_reset, w_start, w_tick;

  snake_engine dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .game_tick(game_tick),
    .snake_direction(snake_direction), .food_x(food_x), .food_y(food_y),
    .video_on(video_on), .x(px), .y(py), .rgb(rgb), .score(score),
    .snake_length(snake_length), .food_eaten(food_eaten), .game_over(game_over));

  snake_engine #(.WRAP_MODE(1)) u_wrap (
    .clk_100MHz(clk_100MHz), .reset(w_reset), .start(w_start), .game_tick(w_tick),
    .snake_direction(snake_direction), .food_x(food_x), .food_y(food_y),
    .video_on(video_on), .x(px), .y(py), .rgb(rgb_w), .score(score_w),
    .snake_length(len_w), .food_eaten(eaten_w), .game_over(over_w));

  int n_asrt = 0, n_fail = 0;

  // reference model: snake as coordinate queues, head at index 0
  int qx[$], qy[$];
  int m_st, m_cur, m_pend, m_score;
  bit m_eaten, m_over;

  function automatic int ddx(input int d); return (d == 0) ? 1 : (d == 2) ? -1 : 0; endfunction
  function automatic int ddy(input int d); return (d == 3) ? 1 : (d == 1) ? -1 : 0; endfunction

  function automatic void m_init_snake();
    qx = {}; qy = {};
    for (int i = 0; i < IL; i++) begin qx.push_back(GW / 2 - i); qy.push_back(GH / 2); end
    m_cur = 0; m_pend = 0;
  endfunction

  function automatic void m_reset();
    m_init_snake();
    m_st = M_IDLE; m_score = 0; m_eaten = 0; m_over = 0;
  endfunction

  function automatic void m_step();
    int old_cur, old_pend, nx, ny, lim;
    bit dead, grow;
    if (reset) begin m_reset(); return; end
    m_eaten = 0;
    if (m_st != M_RUN) begin
      if (start) begin m_init_snake(); m_score = 0; m_over = 0; m_st = M_RUN; end
      return;
    end
    old_cur = m_cur; old_pend = m_pend;
    if (game_tick) begin
      nx = qx[0] + ddx(old_pend);
      ny = qy[0] + ddy(old_pend);
      dead = (nx < 0 || nx >= GW || ny < 0 || ny >= GH);
      grow = (nx == int'(food_x)) && (ny == int'(food_y));
      lim = grow ? qx.size() : qx.size() - 1;
      for (int i = 1; i < lim; i++) if (qx[i] == nx && qy[i] == ny) dead = 1;
      if (dead) begin
        m_over = 1; m_st = M_OVER;
      end else begin
        qx.push_front(nx); qy.push_front(ny);
        if (!grow || qx.size() > ML) begin void'(qx.pop_back()); void'(qy.pop_back()); end
        if (grow) begin m_eaten = 1; if (m_score < 255) m_score++; end
      end
      m_cur = old_pend;
    end
    if (int'(snake_direction) != (old_cur + 2) % 4) m_pend = int'(snake_direction);
  endfunction

  function automatic int m_rgb(input int ax, input int ay, input bit vo);
    int cx, cy;
    bit dead;
    if (!vo || ax >= GW * CS || ay >= GH * CS) return 0;
    cx = ax / CS; cy = ay / CS;
    dead = (m_st == M_OVER);
    if (cx == int'(food_x) && cy == int'(food_y)) return C_FOOD;
    if (cx == qx[0] && cy == qy[0]) return dead ? C_DEAD : C_HEAD;
    for (int i = 1; i < qx.size(); i++) if (cx == qx[i] && cy == qy[i]) return dead ? C_DEAD : C_SNAKE;
    return C_BG;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic probe(input string tag, input int ax, input int ay, input bit vo);
    px = 10'(ax); py = 10'(ay); video_on = vo;
    #1;
    chk(tag, 32'(rgb), 32'(m_rgb(ax, ay, vo)));
    video_on = 1'b1;
  endtask

  task automatic pconst(input string tag, input int cx, input int cy, input int exp);
    px = 10'(cx * CS + 4); py = 10'(cy * CS + 4); video_on = 1'b1;
    #1;
    chk(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic check_outs();
    chk("score", 32'(score), 32'(m_score));
    chk("length", 32'(snake_length), 32'(qx.size()));
    chk("food_eaten", 32'(food_eaten), 32'(m_eaten));
    chk("game_over", 32'(game_over), 32'(m_over));
    for (int i = 0; i < qx.size(); i++)
      probe("seg_px", qx[i] * CS + int'($urandom_range(CS - 1)), qy[i] * CS + int'($urandom_range(CS - 1)), 1'b1);
    probe("food_px", int'(food_x) * CS + int'($urandom_range(CS - 1)), int'(food_y) * CS, 1'b1);
    probe("rand_px", int'($urandom_range(719)), int'($urandom_range(539)), 1'b1);
    probe("blank_px", int'($urandom_range(639)), int'($urandom_range(479)), 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk_100MHz);
    m_step();
    #1;
  endtask

  task automatic step(input bit tk);
    game_tick = tk;
    cyc();
    game_tick = 1'b0;
    check_outs();
  endtask

  initial begin
    int fx, fy, k;
    reset = 1'b1; start = 1'b0; game_tick = 1'b0; snake_direction = 2'd0;
    food_x = 6'd0; food_y = 6'd0; video_on = 1'b1; px = '0; py = '0;
    w_reset = 1'b1; w_start = 1'b0; w_tick = 1'b0;
    m_reset();
    cyc();
    check_outs();
    pconst("rst_head", 32, 24, C_HEAD);
    pconst("rst_tail", 30, 24, C_SNAKE);
    pconst("rst_bg", 29, 24, C_BG);
    reset = 1'b0;

    // start, one move
    start = 1'b1; step(1'b0); start = 1'b0;
    step(1'b1);
    chk("len_after_move", 32'(snake_length), 32'd3);
    pconst("move_head", 33, 24, C_HEAD);
    pconst("move_body", 31, 24, C_SNAKE);
    pconst("move_vacated", 30, 24, C_BG);

    // eat: pulse, growth, tail kept
    food_x = 6'd34; food_y = 6'd24;
    step(1'b1);
    chk("eat_pulse", 32'(food_eaten), 32'd1);
    chk("eat_len", 32'(snake_length), 32'd4);
    chk("eat_score", 32'(score), 32'd1);
    pconst("eat_tail", 31, 24, C_SNAKE);
    step(1'b1);
    chk("eat_pulse_end", 32'(food_eaten), 32'd0);
    food_x = 6'd0; food_y = 6'd0;

    // reversal ignored, then turn up
    snake_direction = 2'd2; step(1'b0); step(1'b1);
    pconst("rev_ignored", 36, 24, C_HEAD);
    snake_direction = 2'd1; step(1'b0); step(1'b1);
    pconst("turn_up", 36, 23, C_HEAD);

    // right wall
    reset = 1'b1; #1; m_reset(); cyc(); reset = 1'b0;
    snake_direction = 2'd0;
    start = 1'b1; step(1'b0); start = 1'b0;
    repeat (31) step(1'b1);
    pconst("wall_edge", 63, 24, C_HEAD);
    step(1'b1);
    chk("wall_over", 32'(game_over), 32'd1);
    pconst("wall_head_stays", 63, 24, C_DEAD);
    pconst("wall_body_dead", 62, 24, C_DEAD);
    start = 1'b1; step(1'b0); start = 1'b0;
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_len", 32'(snake_length), 32'd3);
    chk("restart_score", 32'(score), 32'd0);

    // grow to 5, then turn into own body
    food_x = 6'd33; food_y = 6'd24; step(1'b1);
    food_x = 6'd34; step(1'b1);
    food_x = 6'd0; food_y = 6'd0;
    chk("len5", 32'(snake_length), 32'd5);
    snake_direction = 2'd1; step(1'b0); step(1'b1);
    snake_direction = 2'd2; step(1'b0); step(1'b1);
    snake_direction = 2'd3; step(1'b0); step(1'b1);
    chk("self_hit", 32'(game_over), 32'd1);

    // asynchronous reset in the middle of a tick
    start = 1'b1; step(1'b0); start = 1'b0;
    snake_direction = 2'd0;
    step(1'b1); step(1'b1);
    game_tick = 1'b1;
    #20 reset = 1'b1;
    #1 m_reset();
    check_outs();
    chk("async_len", 32'(snake_length), 32'd3);
    chk("async_score", 32'(score), 32'd0);
    pconst("async_head", 32, 24, C_HEAD);
    cyc();
    game_tick = 1'b0; reset = 1'b0;
    check_outs();

    // wrap-mode instance runs off the right edge
    w_reset = 1'b0; food_x = 6'd10; food_y = 6'd10;
    w_start = 1'b1; cyc(); w_start = 1'b0;
    w_tick = 1'b1; repeat (32) cyc(); w_tick = 1'b0;
    px = 10'(0 * CS + 5); py = 10'(24 * CS + 5); #1;
    chk("wrap_head", 32'(rgb_w), 32'(C_HEAD));
    px = 10'(63 * CS + 5); #1;
    chk("wrap_body", 32'(rgb_w), 32'(C_SNAKE));
    chk("wrap_alive", 32'(over_w), 32'd0);
    chk("wrap_len", 32'(len_w), 32'd3);
    food_x = 6'd0; food_y = 6'd0;

    // random play with food dropped ahead of the snake
    repeat (300) begin
      if ($urandom_range(99) < 30) snake_direction = 2'($urandom_range(3));
      start = ($urandom_range(7) == 0);
      if ($urandom_range(5) == 0) begin
        k = 1 + int'($urandom_range(2));
        fx = qx[0] + ddx(m_pend) * k; fy = qy[0] + ddy(m_pend) * k;
        if (fx < 0) fx = 0; if (fx > GW - 1) fx = GW - 1;
        if (fy < 0) fy = 0; if (fy > GH - 1) fy = GH - 1;
        food_x = 6'(fx); food_y = 6'(fy);
      end
      step(1'($urandom_range(1)));
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
